// File: rtl/checksum_pkg.sv
// Shared types and constants for the cluster-checksum scheduler.
package checksum_pkg;

    localparam int FRAME_BYTES   = 24;
    localparam int CLUSTER_BYTES = 4;

    typedef enum logic [1:0] {
        IDLE,
        ACC,
        EMIT
    } state_t;

    // Two's-complement negation: sum of bytes plus this value wraps to zero.
    function automatic logic [7:0] cs_neg(input logic [7:0] b);
        return ~b + 8'd1;
    endfunction

endpackage

// File: rtl/checksum_acc.sv
// 8-bit wrapping accumulator with clear/add-enable and a registered negated sum.
module checksum_acc
    import checksum_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic       clr,
    input  logic       add_en,
    input  logic       cap,
    input  logic [7:0] din,
    output logic [7:0] cs_data
);

    logic [7:0] acc;
    logic [7:0] sum;

    assign sum = acc + din;

    // NOTE: sequential state always uses non-blocking assignments so every
    // register samples the pre-edge values of its peers.
    always_ff @(posedge clk) begin
        if (rst) begin
            acc     <= 8'h00;
            cs_data <= 8'h00;
        end else begin
            if (clr)
                acc <= 8'h00;
            else if (add_en)
                acc <= sum;
            // Capture includes the byte being added this cycle.
            if (cap)
                cs_data <= cs_neg(sum);
        end
    end

endmodule

// File: rtl/checksum_sched.sv
// Walks a captured frame one byte per clock and emits a checksum per cluster.
module checksum_sched
    import checksum_pkg::*;
#(
    parameter  int FRAME_BYTES_P   = FRAME_BYTES,
    parameter  int CLUSTER_BYTES_P = CLUSTER_BYTES,
    localparam int NCL             = FRAME_BYTES_P / CLUSTER_BYTES_P,
    localparam int CLW             = (NCL > 1) ? $clog2(NCL) : 1,
    localparam int FW              = FRAME_BYTES_P * 8
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           in_valid,
    output logic           in_ready,
    input  logic [FW-1:0]  in_data,
    output logic           cs_valid,
    input  logic           cs_ready,
    output logic [7:0]     cs_data,
    output logic [CLW-1:0] cs_index,
    output logic           frame_done,
    output logic           busy
);

    localparam int BCW = (CLUSTER_BYTES_P > 1) ? $clog2(CLUSTER_BYTES_P) : 1;

    state_t         state, state_nx;
    logic [FW-1:0]  frame_sr;
    logic [BCW-1:0] byte_cnt;
    logic [CLW-1:0] cl_cnt;
    logic           accept, last_byte, last_cl, cs_hs;

    assign accept    = in_valid && in_ready;
    assign last_byte = (byte_cnt == BCW'(CLUSTER_BYTES_P - 1));
    assign last_cl   = (cl_cnt == CLW'(NCL - 1));
    assign cs_hs     = cs_valid && cs_ready;

    always_ff @(posedge clk) begin
        if (rst)
            state <= IDLE;
        else
            state <= state_nx;
    end

    // NOTE: every combinational output gets a default first so no path
    // through the case leaves it unassigned and infers a latch.
    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    if (accept)                  state_nx = ACC;
            ACC:     if (last_byte)               state_nx = EMIT;
            EMIT:    if (cs_hs)                   state_nx = last_cl ? IDLE : ACC;
            default:                              state_nx = IDLE;
        endcase
    end

    always_comb begin
        in_ready = 1'b0;
        cs_valid = 1'b0;
        busy     = 1'b1;
        case (state)
            IDLE: begin
                in_ready = !rst;
                busy     = 1'b0;
            end
            EMIT:    cs_valid = 1'b1;
            default: ;
        endcase
    end

    // NOTE: the frame shift register is pure datapath overwritten on every
    // accept, so it carries no reset.
    always_ff @(posedge clk) begin
        if (accept)
            frame_sr <= in_data;
        else if (state == ACC)
            frame_sr <= {frame_sr[FW-9:0], 8'h00};
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            byte_cnt   <= '0;
            cl_cnt     <= '0;
            cs_index   <= '0;
            frame_done <= 1'b0;
        end else begin
            frame_done <= cs_hs && last_cl;
            if (accept) begin
                byte_cnt <= '0;
                cl_cnt   <= '0;
            end else if (state == ACC) begin
                byte_cnt <= last_byte ? '0 : byte_cnt + BCW'(1);
                if (last_byte)
                    cs_index <= cl_cnt;
            end else if (cs_hs && !last_cl) begin
                cl_cnt <= cl_cnt + CLW'(1);
            end
        end
    end

    checksum_acc u_acc (
        .clk     (clk),
        .rst     (rst),
        .clr     (accept || (cs_hs && !last_cl)),
        .add_en  (state == ACC),
        .cap     ((state == ACC) && last_byte),
        .din     (frame_sr[FW-1 -: 8]),
        .cs_data (cs_data)
    );

endmodule

// File: tb/tb_checksum_sched.sv
// Scoreboard bench for checksum_sched: expected checksums queued at stimulus time.
module tb_checksum_sched;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         in_valid = 1'b0;
    logic         in_ready;
    logic [191:0] in_data = '0;
    logic         cs_valid;
    logic         cs_ready = 1'b1;
    logic [7:0]   cs_data;
    logic [2:0]   cs_index;
    logic         frame_done;
    logic         busy;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int hs_count = 0;

    typedef struct packed {
        logic [7:0] data;
        logic [2:0] idx;
    } exp_t;
    exp_t exp_q[$];

    localparam logic [191:0] F_ABCD = {6{32'h41424344}};
    localparam logic [191:0] F_ZERO = '0;
    localparam logic [191:0] F_FF   = {24{8'hFF}};

    checksum_sched dut (
        .clk        (clk),
        .rst        (rst),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_data    (in_data),
        .cs_valid   (cs_valid),
        .cs_ready   (cs_ready),
        .cs_data    (cs_data),
        .cs_index   (cs_index),
        .frame_done (frame_done),
        .busy       (busy)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Scoreboard: every handshake due at the next rising edge is popped and compared.
    always @(negedge clk) begin
        if (!rst && cs_valid && cs_ready) begin
            exp_t e;
            hs_count++;
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL sb_extra: got data=%02h idx=%0d, expected no checksum", cs_data, cs_index);
            end else begin
                e = exp_q.pop_front();
                if ({cs_data, cs_index} !== e) begin
                    errors++;
                    $display("FAIL sb_checksum: got data=%02h idx=%0d, expected data=%02h idx=%0d",
                             cs_data, cs_index, e.data, e.idx);
                end
            end
        end
    end

    function automatic void push_frame(input logic [191:0] f);
        for (int c = 0; c < 6; c++) begin
            int s = 0;
            for (int b = 0; b < 4; b++)
                s += int'(f[191 - 8 * (4 * c + b) -: 8]);
            exp_q.push_back({8'((256 - (s % 256)) % 256), 3'(c)});
        end
    endfunction

    task automatic send_frame(input logic [191:0] f, output int t_acc);
        int n = 0;
        @(negedge clk);
        while (!in_ready && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (!in_ready) begin
            checks++;
            errors++;
            $display("FAIL send_timeout: in_ready=%b, expected 1", in_ready);
            t_acc = cyc;
            return;
        end
        in_data  = f;
        in_valid = 1'b1;
        @(posedge clk);
        #1 in_valid = 1'b0;
        @(negedge clk);
        t_acc = cyc;
    endtask

    task automatic wait_frame_done(input string name, output int at);
        int n = 0;
        while (!frame_done && n < 200) begin
            @(negedge clk);
            n++;
        end
        at = cyc;
        if (!frame_done) begin
            checks++;
            errors++;
            $display("FAIL %s_done_timeout: frame_done=%b, expected 1", name, frame_done);
        end
    endtask

    task automatic check_int(input string name, input int got, input int want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d", name, got, want);
        end
    endtask

    task automatic check_queue_empty(input string name);
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL %s_missing: %0d checksums outstanding, expected 0", name, exp_q.size());
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        checks++;
        if ({cs_valid, cs_data, cs_index, frame_done, busy, in_ready} !== 14'h0) begin
            errors++;
            $display("FAIL reset_values: got valid=%b data=%02h idx=%0d done=%b busy=%b ready=%b, expected all 0",
                     cs_valid, cs_data, cs_index, frame_done, busy, in_ready);
        end
        @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        checks++;
        if (in_ready !== 1'b1) begin
            errors++;
            $display("FAIL reset_in_ready: got %b, expected 1", in_ready);
        end
    endtask

    task automatic test_abcd();
        int t_acc, t_done, t_valid, n, hs0;
        hs0 = hs_count;
        cs_ready = 1'b1;
        push_frame(F_ABCD);
        send_frame(F_ABCD, t_acc);
        n = 0;
        while (!cs_valid && n < 50) begin
            @(negedge clk);
            n++;
        end
        t_valid = cyc;
        check_int("abcd_first_valid_latency", t_valid - t_acc, 4);
        wait_frame_done("abcd", t_done);
        check_int("abcd_done_latency", t_done - t_acc, 30);
        checks++;
        if (in_ready !== 1'b1) begin
            errors++;
            $display("FAIL abcd_ready_at_done: got %b, expected 1", in_ready);
        end
        check_int("abcd_hs_count", hs_count - hs0, 6);
        check_queue_empty("abcd");
    endtask

    task automatic test_zero_ff();
        int t_acc, t_done, hs0;
        hs0 = hs_count;
        push_frame(F_ZERO);
        send_frame(F_ZERO, t_acc);
        wait_frame_done("zero", t_done);
        push_frame(F_FF);
        send_frame(F_FF, t_acc);
        wait_frame_done("ff", t_done);
        check_int("zero_ff_hs_count", hs_count - hs0, 12);
        check_queue_empty("zero_ff");
    endtask

    task automatic test_backpressure();
        int t_acc, t_done, bad;
        bad = 0;
        push_frame(F_ABCD);
        send_frame(F_ABCD, t_acc);
        repeat (14) @(posedge clk);
        #1 cs_ready = 1'b0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (cs_valid !== 1'b1 || cs_data !== 8'hF6 || cs_index !== 3'd2)
                bad++;
        end
        check_int("bp_hold_stable_violations", bad, 0);
        @(posedge clk);
        #1 cs_ready = 1'b1;
        wait_frame_done("bp", t_done);
        check_int("bp_done_latency", t_done - t_acc, 40);
        check_queue_empty("bp");
    endtask

    task automatic test_reset_mid();
        int t_acc, t_done, hs0, seen;
        hs0 = hs_count;
        seen = 0;
        cs_ready = 1'b1;
        push_frame(F_ABCD);
        send_frame(F_ABCD, t_acc);
        repeat (11) @(posedge clk);
        #1 rst = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
        exp_q.delete();
        @(negedge clk);
        checks++;
        if (in_ready !== 1'b1 || busy !== 1'b0) begin
            errors++;
            $display("FAIL rst_mid_idle: got ready=%b busy=%b, expected ready=1 busy=0", in_ready, busy);
        end
        check_int("rst_mid_hs_before", hs_count - hs0, 2);
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (cs_valid) seen++;
        end
        check_int("rst_mid_stray_valid", seen, 0);
        hs0 = hs_count;
        push_frame(F_ABCD);
        send_frame(F_ABCD, t_acc);
        wait_frame_done("rst_mid", t_done);
        check_int("rst_mid_new_frame_hs", hs_count - hs0, 6);
        check_queue_empty("rst_mid");
    endtask

    task automatic test_back_to_back();
        int acc_n, acc1, acc2, fd2, n, t_done, hs0;
        hs0 = hs_count;
        acc_n = 0;
        acc1 = 0;
        acc2 = 0;
        fd2 = 0;
        n = 0;
        cs_ready = 1'b1;
        push_frame(F_ABCD);
        push_frame(F_FF);
        @(negedge clk);
        in_data  = F_ABCD;
        in_valid = 1'b1;
        while (acc_n < 2 && n < 200) begin
            if (in_valid && in_ready) begin
                acc_n++;
                if (acc_n == 1) begin
                    acc1 = cyc;
                    @(posedge clk);
                    #1 in_data = F_FF;
                end else begin
                    acc2 = cyc;
                    fd2 = int'(frame_done);
                    @(posedge clk);
                    #1 in_valid = 1'b0;
                end
            end
            @(negedge clk);
            n++;
        end
        in_valid = 1'b0;
        check_int("b2b_accepts", acc_n, 2);
        check_int("b2b_spacing", acc2 - acc1, 31);
        check_int("b2b_accept_in_done_cycle", fd2, 1);
        wait_frame_done("b2b", t_done);
        check_int("b2b_hs_count", hs_count - hs0, 12);
        check_queue_empty("b2b");
    endtask

    task automatic test_ignore();
        int t_acc, t_done, bad;
        bad = 0;
        cs_ready = 1'b1;
        push_frame(F_ABCD);
        send_frame(F_ABCD, t_acc);
        for (int i = 0; i < 28; i++) begin
            in_valid = (i % 3 == 0);
            in_data  = F_FF;
            @(negedge clk);
            if (in_ready !== 1'b0 || busy !== 1'b1) bad++;
        end
        in_valid = 1'b0;
        check_int("ignore_ready_low_violations", bad, 0);
        wait_frame_done("ignore", t_done);
        check_int("ignore_done_latency", t_done - t_acc, 30);
        check_queue_empty("ignore");
    endtask

    initial begin
        test_reset();
        test_abcd();
        test_zero_ff();
        test_backpressure();
        test_reset_mid();
        test_back_to_back();
        test_ignore();
        repeat (3) @(negedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
